// File: rtl/pong_autopilot.sv
// rtl/pong_autopilot.sv - paddle/serve command generator for the pong game controller
//
// Purpose:
//   Runs once per frame. In auto mode it steers the paddle toward the ball and
//   serves after a fixed delay. In manual mode it registers the player's buttons
//   and serves on a rising edge of the start input. It also counts misses, where
//   a miss is the ball coming back to its home position during play.
//
// Ports:
//   clk_frame_i  in   frame clock, one rising edge per game update
//   rst_i        in   asynchronous active-high reset
//   auto_en_i    in   1 = autopilot, 0 = manual
//   man_btn_i    in   [0] down (+y), [1] up (-y), raw manual buttons
//   man_start_i  in   raw manual start level
//   ball_x_i     in   current ball x
//   ball_y_i     in   current ball y
//   pad_y_i      in   current paddle top y (paddle is 64 px tall)
//   btn_o        out  button command, same encoding as man_btn_i, never 11
//   start_o      out  one-frame start pulse
//   miss_cnt_o   out  saturating miss counter
//   state_o      out  0 WAIT_SERVE, 1 SERVE, 2 PLAY

module pong_autopilot #(
    parameter int SERVE_DELAY = 60,
    parameter int DEAD_BAND   = 4,
    parameter int REACT_X     = 320,
    parameter int CENTER_Y    = 207,
    parameter int HOME_X      = 36,
    parameter int HOME_Y      = 8
) (
    input  logic       clk_frame_i,
    input  logic       rst_i,
    input  logic       auto_en_i,
    input  logic [1:0] man_btn_i,
    input  logic       man_start_i,
    input  logic [9:0] ball_x_i,
    input  logic [9:0] ball_y_i,
    input  logic [9:0] pad_y_i,
    output logic [1:0] btn_o,
    output logic       start_o,
    output logic [7:0] miss_cnt_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        WAIT_SERVE = 2'd0,
        SERVE      = 2'd1,
        PLAY       = 2'd2,
        BAD_STATE  = 2'd3
    } state_t;

    localparam logic [7:0]  SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [10:0] DB         = 11'(DEAD_BAND);
    localparam logic [10:0] IDLE_MID   = 11'(CENTER_Y + 32);
    localparam logic [9:0]  REACT_X_V  = 10'(REACT_X);
    localparam logic [9:0]  HOME_X_V   = 10'(HOME_X);
    localparam logic [9:0]  HOME_Y_V   = 10'(HOME_Y);

    state_t     state_q, state_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic       left_home_q, left_home_d;
    logic [7:0] miss_cnt_q, miss_cnt_d;
    logic       man_start_q;
    logic       auto_q;
    logic [1:0] btn_q, btn_d;
    logic       start_q, start_d;

    logic        at_home;
    logic        man_start_rise;
    logic [10:0] centre;
    logic [10:0] target_top;
    logic [1:0]  steer_btn;

    assign at_home        = (ball_x_i == HOME_X_V) && (ball_y_i == HOME_Y_V);
    assign man_start_rise = man_start_i & ~man_start_q;

    // 11-bit arithmetic so pad_y + 32 and the dead-band sums cannot wrap.
    assign centre     = {1'b0, pad_y_i} + 11'd32;
    assign target_top = ((ball_x_i >= REACT_X_V) || (state_q != PLAY)) ? IDLE_MID
                                                                        : {1'b0, ball_y_i};

    always_comb begin
        steer_btn = 2'b00;
        if (target_top > centre + DB) begin
            steer_btn = 2'b01;
        end else if (target_top + DB < centre) begin
            steer_btn = 2'b10;
        end
    end

    always_comb begin
        state_d     = state_q;
        serve_cnt_d = serve_cnt_q;
        left_home_d = left_home_q;
        miss_cnt_d  = miss_cnt_q;

        case (state_q)
            WAIT_SERVE: begin
                left_home_d = 1'b0;
                if (auto_en_i) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_d     = SERVE;
                        serve_cnt_d = 8'd0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 8'd1;
                    end
                end else begin
                    serve_cnt_d = 8'd0;
                    if (man_start_rise) begin
                        state_d = SERVE;
                    end
                end
            end
            SERVE: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (!at_home) begin
                    left_home_d = 1'b1;
                end
                // The ball sits at home for a few frames after the serve; only a
                // return after it has actually moved away counts as a miss.
                if (left_home_q && at_home) begin
                    if (miss_cnt_q != 8'hFF) begin
                        miss_cnt_d = miss_cnt_q + 8'd1;
                    end
                    state_d     = WAIT_SERVE;
                    serve_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d     = WAIT_SERVE;
                serve_cnt_d = 8'd0;
            end
        endcase

        // A mode flip restarts the serve delay from zero.
        if (auto_en_i != auto_q) begin
            serve_cnt_d = 8'd0;
        end

        start_d = (state_q == SERVE);

        if (auto_en_i) begin
            btn_d = steer_btn;
        end else if (man_btn_i == 2'b11) begin
            btn_d = 2'b00;
        end else begin
            btn_d = man_btn_i;
        end
    end

    // auto_q resets to 1 so an auto-mode start does not see a spurious mode
    // change on the first frame; in manual mode the counter is held at 0 anyway.
    always_ff @(posedge clk_frame_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= WAIT_SERVE;
            serve_cnt_q <= 8'd0;
            left_home_q <= 1'b0;
            miss_cnt_q  <= 8'd0;
            man_start_q <= 1'b0;
            auto_q      <= 1'b1;
            btn_q       <= 2'b00;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            serve_cnt_q <= serve_cnt_d;
            left_home_q <= left_home_d;
            miss_cnt_q  <= miss_cnt_d;
            man_start_q <= man_start_i;
            auto_q      <= auto_en_i;
            btn_q       <= btn_d;
            start_q     <= start_d;
        end
    end

    assign btn_o      = btn_q;
    assign start_o    = start_q;
    assign miss_cnt_o = miss_cnt_q;
    assign state_o    = state_q;

endmodule
